// File: rtl/bb_mem_ctrl_pkg.sv
// Shared encodings for bb_mem_ctrl: FSM states, access kinds and core enable codes.
// DATA_WIDTH defaults here when the project-wide `DATA_WIDTH define is absent.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package bb_mem_ctrl_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      KIND_FETCH = 2'd0,
      KIND_LOAD  = 2'd1,
      KIND_STORE = 2'd2
   } access_kind_e;

   localparam logic [1:0] OEN_IDLE  = 2'b00;
   localparam logic [1:0] OEN_FETCH = 2'b01;
   localparam logic [1:0] OEN_LOAD  = 2'b10;
   localparam logic [1:0] OEN_RSVD  = 2'b11;

   // Any write enable wins over a simultaneous read; the reserved read code behaves as a load.
   function automatic access_kind_e decode_kind(input logic [1:0] oen, input logic [1:0] ien);
      access_kind_e k;
      k = KIND_LOAD;
      if (ien != 2'b00) begin
         k = KIND_STORE;
      end else begin
         case (oen)
            OEN_FETCH:          k = KIND_FETCH;
            OEN_LOAD, OEN_RSVD: k = KIND_LOAD;
            default:            k = KIND_LOAD;
         endcase
      end
      return k;
   endfunction

endpackage

// File: rtl/bb_mem_fetch_buf.sv
// One-entry fetch buffer (valid/tag/data) with combinational hit compare.
// Exists only when BB_MEM_FETCH_BUF_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

`ifdef BB_MEM_FETCH_BUF_EN
module bb_mem_fetch_buf
   import bb_mem_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = `DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] lookup_addr,
   output logic                  hit,
   output logic [DATA_WIDTH-1:0] hit_data,
   input  logic                  fill,
   input  logic [DATA_WIDTH-1:0] fill_tag,
   input  logic [DATA_WIDTH-1:0] fill_data,
   input  logic                  inval,
   input  logic [DATA_WIDTH-1:0] inval_addr
);

   logic                  valid;
   logic [DATA_WIDTH-1:0] tag;
   logic [DATA_WIDTH-1:0] data;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         tag   <= '0;
         data  <= '0;
      end else if (fill) begin
         valid <= 1'b1;
         tag   <= fill_tag;
         data  <= fill_data;
      end else if (inval && (inval_addr == tag)) begin
         valid <= 1'b0;
      end
   end

   assign hit      = valid && (tag == lookup_addr);
   assign hit_data = data;

endmodule
`endif

// File: rtl/bb_mem_ctrl.sv
// Core-side memory controller: fetch/load/store to a req/ack memory with timeout and sticky error.
// Optional one-entry fetch buffer selected by BB_MEM_FETCH_BUF_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module bb_mem_ctrl
   import bb_mem_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = `DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TO_CNT_W       = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            i_ins_oen,
   input  logic [1:0]            i_ins_ien,
   input  logic [DATA_WIDTH-1:0] i_ins_addr,
   input  logic [DATA_WIDTH-1:0] i_ins_pc,
   input  logic [DATA_WIDTH-1:0] i_ins_data,
   output logic [DATA_WIDTH-1:0] o_ins_data,
   output logic                  o_ins_ready,
   output logic                  o_err,
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic [DATA_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic                  i_mem_ack,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

   logic [1:0]            state;
   access_kind_e          kind;
   logic [DATA_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  we_q;
   logic                  err_q;
   logic [TO_CNT_W-1:0]   to_cnt;

   access_kind_e          kind_next;
   logic [DATA_WIDTH-1:0] addr_next;
   logic                  req_present;
   logic                  bad_read;
   logic                  in_req;
   logic                  mem_done;
   logic                  timed_out;
   logic                  fetch_hit;
   logic [DATA_WIDTH-1:0] hit_data;

   always_comb begin
      kind_next   = decode_kind(i_ins_oen, i_ins_ien);
      addr_next   = (kind_next == KIND_FETCH) ? i_ins_pc : i_ins_addr;
      req_present = (i_ins_oen != OEN_IDLE) || (i_ins_ien != 2'b00);
      bad_read    = ((i_ins_ien != 2'b00) && (i_ins_oen != OEN_IDLE)) || (i_ins_oen == OEN_RSVD);
      in_req      = (state == ST_REQ);
      mem_done    = in_req && i_mem_ack;
      timed_out   = in_req && !i_mem_ack && (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
   end

`ifdef BB_MEM_FETCH_BUF_EN
   logic buf_hit;

   bb_mem_fetch_buf #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_fetch_buf (
      .clk        (clk),
      .rst        (rst),
      .lookup_addr(i_ins_pc),
      .hit        (buf_hit),
      .hit_data   (hit_data),
      .fill       (mem_done && (kind == KIND_FETCH)),
      .fill_tag   (addr_q),
      .fill_data  (i_mem_rdata),
      .inval      (mem_done && (kind == KIND_STORE)),
      .inval_addr (addr_q)
   );

   assign fetch_hit = (state == ST_IDLE) && (kind_next == KIND_FETCH) && buf_hit;
`else
   assign fetch_hit = 1'b0;
   assign hit_data  = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         kind    <= KIND_FETCH;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         to_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_present) begin
                  kind    <= kind_next;
                  addr_q  <= addr_next;
                  we_q    <= (kind_next == KIND_STORE);
                  wdata_q <= (kind_next == KIND_STORE) ? i_ins_data : '0;
                  to_cnt  <= '0;
                  if (bad_read) begin
                     err_q <= 1'b1;
                  end
                  // A buffered fetch skips the memory and completes one cycle later.
                  if (fetch_hit) begin
                     rdata_q <= hit_data;
                     state   <= ST_DONE;
                  end else begin
                     rdata_q <= '0;
                     state   <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (mem_done) begin
                  rdata_q <= (kind == KIND_STORE) ? '0 : i_mem_rdata;
                  to_cnt  <= '0;
                  state   <= ST_DONE;
               end else if (timed_out) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  to_cnt  <= '0;
                  state   <= ST_DONE;
               end else begin
                  to_cnt <= to_cnt + TO_CNT_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      o_mem_req   = in_req;
      o_mem_we    = in_req && we_q;
      o_mem_addr  = in_req ? addr_q : '0;
      o_mem_wdata = in_req ? wdata_q : '0;
      o_ins_ready = (state == ST_DONE);
      o_ins_data  = ((state == ST_DONE) && (kind != KIND_STORE)) ? rdata_q : '0;
      o_err       = err_q;
   end

endmodule
